lsu_resp_wb: RTL and testbench

- Next-generation LSU writeback stage: accepts load/store issue records from idex and tracks up to DEPTH in-flight accesses in an in-order pending queue.
- Merges in-order responses from NSRC memory ports (port 0 = DTCM, port 1 = ITCM); extracts and extends the addressed byte/halfword lane using the address offset.
- Presents one registered result per access to WB through a valid/ready handshake; flags misaligned and bus-error faults to the EIU.

---
 rtl/lsu_resp_wb_pkg.sv | 27 ++
 rtl/lsu_resp_wb_load_align.sv | 31 +++
 rtl/lsu_resp_wb.sv | 173 +++++++++++++++++
 tb/tb_lsu_resp_wb.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_resp_wb_pkg.sv
// Shared LSU writeback definitions: data width, load-op one-hot encoding
// and the layout of one pending-queue entry.
package lsu_resp_wb_pkg;

  localparam int ZCRV_XLEN = 32;

  // One-hot load operation, bit order {lb, lh, lw, lbu, lhu}
  typedef enum logic [4:0] {
    OP_LHU = 5'b00001,
    OP_LBU = 5'b00010,
    OP_LW  = 5'b00100,
    OP_LH  = 5'b01000,
    OP_LB  = 5'b10000
  } load_op_e;

  // One in-flight access waiting for its memory response
  typedef struct packed {
    logic       load;
    logic [4:0] info;
    logic [4:0] rd;
    logic [1:0] offset;
    logic       misalgn;
  } pend_entry_t;

  localparam int PEND_ENTRY_W = $bits(pend_entry_t);

endpackage

// File: rtl/lsu_resp_wb_load_align.sv
// Combinational load lane select and extend: picks the addressed byte or
// halfword out of a read word and sign/zero extends it to the full width.
module lsu_load_align
  import lsu_resp_wb_pkg::*;
(
  input  logic [ZCRV_XLEN-1:0] i_data,
  input  logic [1:0]           i_offset,
  input  logic [4:0]           i_info,
  output logic [ZCRV_XLEN-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_data[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_data[31:16] : i_data[15:0];

  // Extend the selected lane according to the one-hot op; anything else reads as 0
  always_comb begin
    o_result = '0;
    case (i_info)
      OP_LB:   o_result = {{(ZCRV_XLEN-8){w_byte[7]}}, w_byte};
      OP_LH:   o_result = {{(ZCRV_XLEN-16){w_half[15]}}, w_half};
      OP_LW:   o_result = i_data;
      OP_LBU:  o_result = {{(ZCRV_XLEN-8){1'b0}}, w_byte};
      OP_LHU:  o_result = {{(ZCRV_XLEN-16){1'b0}}, w_half};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_resp_wb.sv
// LSU writeback stage: in-order queue of issued accesses, merges memory
// responses from the TCM ports and hands one registered result per access
// to WB, reporting misaligned and bus-error faults to the EIU.
module lsu_resp_wb
  import lsu_resp_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NSRC  = 2,
  parameter int XLEN  = ZCRV_XLEN
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_load,
  input  logic [4:0]         i_req_info,
  input  logic [4:0]         i_req_rd,
  input  logic [1:0]         i_req_offset,
  input  logic               i_req_misalgn,
  input  logic [NSRC-1:0]    i_rsp_valid,
  input  logic [NSRC*XLEN-1:0] i_rsp_data,
  input  logic [NSRC-1:0]    i_rsp_err,
  output logic               o_rsp_ready,
  output logic               o_wb_valid,
  input  logic               i_wb_ready,
  output logic               o_wb_rden,
  output logic [4:0]         o_wb_rd_index,
  output logic [XLEN-1:0]    o_wb_rd_data,
  output logic               o_load_success,
  output logic               o_store_success,
  output logic               o_load_misalgn_to_eiu,
  output logic               o_load_buserr_to_eiu,
  output logic               o_store_misalgn_to_eiu,
  output logic               o_store_buserr_to_eiu
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [PEND_ENTRY_W-1:0] r_queue [DEPTH];
  logic [PW-1:0]           r_wrPtr;
  logic [PW-1:0]           r_rdPtr;
  logic [PW:0]             r_count;

  logic                    r_wbValid;
  logic                    r_isLoad;
  logic                    r_rden;
  logic [4:0]              r_rdIndex;
  logic [XLEN-1:0]         r_rdData;
  logic                    r_ldMis;
  logic                    r_ldBus;
  logic                    r_stMis;
  logic                    r_stBus;

  pend_entry_t             w_newEntry;
  pend_entry_t             w_head;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_headDone;
  logic                    w_wbFire;
  logic [XLEN-1:0]         w_rspData;
  logic                    w_rspErr;
  logic                    w_busErr;
  logic                    w_faultFree;
  logic [XLEN-1:0]         w_alignData;

  assign w_newEntry = '{load:    i_req_load,
                        info:    i_req_info,
                        rd:      i_req_rd,
                        offset:  i_req_offset,
                        misalgn: i_req_misalgn};
  assign w_head     = pend_entry_t'(r_queue[r_rdPtr]);

  assign o_req_ready = (r_count != FULL_COUNT);
  assign o_rsp_ready = ~r_wbValid | i_wb_ready;
  assign w_wbFire    = r_wbValid & i_wb_ready;

  // A misaligned head never went to memory, so it retires without a response
  assign w_headDone  = (r_count != '0) & o_rsp_ready & (w_head.misalgn | (|i_rsp_valid));
  assign w_push      = i_req_valid & o_req_ready;
  assign w_pop       = w_headDone;

  assign w_busErr    = ~w_head.misalgn & w_rspErr;
  assign w_faultFree = ~w_head.misalgn & ~w_rspErr;

  // Merge the ports; at most one strobe is set, so OR-ing the qualified lanes selects it
  always_comb begin
    w_rspData = '0;
    w_rspErr  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (i_rsp_valid[i]) begin
        w_rspData = w_rspData | i_rsp_data[i*XLEN +: XLEN];
        w_rspErr  = w_rspErr | i_rsp_err[i];
      end
    end
  end

  lsu_load_align u_align (
    .i_data   (w_rspData),
    .i_offset (w_head.offset),
    .i_info   (w_head.info),
    .o_result (w_alignData)
  );

  // Queue storage needs no reset: only entries below the count are ever read
  always_ff @(posedge i_clk) begin
    if (w_push) r_queue[r_wrPtr] <= w_newEntry;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
  end

  // Output record: load on head completion, hold while stalled, clear on handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wbValid <= 1'b0;
      r_isLoad  <= 1'b0;
      r_rden    <= 1'b0;
      r_rdIndex <= '0;
      r_rdData  <= '0;
      r_ldMis   <= 1'b0;
      r_ldBus   <= 1'b0;
      r_stMis   <= 1'b0;
      r_stBus   <= 1'b0;
    end else if (w_headDone) begin
      r_wbValid <= 1'b1;
      r_isLoad  <= w_head.load;
      r_rden    <= w_head.load & w_faultFree;
      r_rdIndex <= (w_head.load & w_faultFree) ? w_head.rd : '0;
      r_rdData  <= (w_head.load & w_faultFree) ? w_alignData : '0;
      r_ldMis   <= w_head.load & w_head.misalgn;
      r_ldBus   <= w_head.load & w_busErr;
      r_stMis   <= ~w_head.load & w_head.misalgn;
      r_stBus   <= ~w_head.load & w_busErr;
    end else if (w_wbFire) begin
      r_wbValid <= 1'b0;
      r_isLoad  <= 1'b0;
      r_rden    <= 1'b0;
      r_rdIndex <= '0;
      r_rdData  <= '0;
      r_ldMis   <= 1'b0;
      r_ldBus   <= 1'b0;
      r_stMis   <= 1'b0;
      r_stBus   <= 1'b0;
    end
  end

  assign o_wb_valid             = r_wbValid;
  assign o_wb_rden              = r_rden;
  assign o_wb_rd_index          = r_rdIndex;
  assign o_wb_rd_data           = r_rdData;
  assign o_load_misalgn_to_eiu  = r_ldMis;
  assign o_load_buserr_to_eiu   = r_ldBus;
  assign o_store_misalgn_to_eiu = r_stMis;
  assign o_store_buserr_to_eiu  = r_stBus;
  assign o_load_success         = w_wbFire & r_rden;
  assign o_store_success        = w_wbFire & ~r_isLoad & ~r_stMis & ~r_stBus;

  // A response with nothing pending, or on two ports at once, breaks the memory protocol
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
                   (|i_rsp_valid) |-> ((r_count != '0) && $onehot0(i_rsp_valid)));

endmodule

// File: tb/tb_lsu_resp_wb.sv
// Self-checking bench for lsu_resp_wb: directed scenarios then random traffic,
// with expected records queued at issue time and checked by an output monitor.
module tb_lsu_resp_wb;

  localparam int DEPTH = 2;
  localparam int NSRC  = 2;
  localparam int XLEN  = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_req_valid;
  logic               o_req_ready;
  logic               i_req_load;
  logic [4:0]         i_req_info;
  logic [4:0]         i_req_rd;
  logic [1:0]         i_req_offset;
  logic               i_req_misalgn;
  logic [NSRC-1:0]    i_rsp_valid;
  logic [NSRC*XLEN-1:0] i_rsp_data;
  logic [NSRC-1:0]    i_rsp_err;
  logic               o_rsp_ready;
  logic               o_wb_valid;
  logic               i_wb_ready;
  logic               o_wb_rden;
  logic [4:0]         o_wb_rd_index;
  logic [XLEN-1:0]    o_wb_rd_data;
  logic               o_load_success;
  logic               o_store_success;
  logic               o_load_misalgn_to_eiu;
  logic               o_load_buserr_to_eiu;
  logic               o_store_misalgn_to_eiu;
  logic               o_store_buserr_to_eiu;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
    int          needHs;
  } rsp_t;

  logic [43:0] sbQ[$];
  rsp_t        rspQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          hsCount = 0;
  int          issued = 0;
  int          lastMisHs = 0;
  int          rdyPct = 100;
  int          forceStall = 0;
  bit          rspHold = 1'b0;

  lsu_resp_wb #(.DEPTH(DEPTH), .NSRC(NSRC), .XLEN(XLEN)) dut (
    .i_clk                  (clk),
    .i_rst_n                (rst_n),
    .i_req_valid            (i_req_valid),
    .o_req_ready            (o_req_ready),
    .i_req_load             (i_req_load),
    .i_req_info             (i_req_info),
    .i_req_rd               (i_req_rd),
    .i_req_offset           (i_req_offset),
    .i_req_misalgn          (i_req_misalgn),
    .i_rsp_valid            (i_rsp_valid),
    .i_rsp_data             (i_rsp_data),
    .i_rsp_err              (i_rsp_err),
    .o_rsp_ready            (o_rsp_ready),
    .o_wb_valid             (o_wb_valid),
    .i_wb_ready             (i_wb_ready),
    .o_wb_rden              (o_wb_rden),
    .o_wb_rd_index          (o_wb_rd_index),
    .o_wb_rd_data           (o_wb_rd_data),
    .o_load_success         (o_load_success),
    .o_store_success        (o_store_success),
    .o_load_misalgn_to_eiu  (o_load_misalgn_to_eiu),
    .o_load_buserr_to_eiu   (o_load_buserr_to_eiu),
    .o_store_misalgn_to_eiu (o_store_misalgn_to_eiu),
    .o_store_buserr_to_eiu  (o_store_buserr_to_eiu)
  );

  always #5 clk = ~clk;

  // Reference load result from the lane rules, using plain shifts and arithmetic
  function automatic logic [31:0] refLoad(input logic [4:0] info, input logic [1:0] off,
                                          input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * (off / 2))) & 32'hFFFF;
    case (info)
      5'b10000: return (b >= 128)   ? b + 32'hFFFFFF00 : b;
      5'b01000: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      5'b00100: return d;
      5'b00010: return b;
      5'b00001: return h;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Issue one access; when tracked, queue its expected record and its memory response
  task automatic applyStimulus(input logic ld, input logic [4:0] info, input logic [4:0] rd,
                               input logic [1:0] off, input logic mis, input int port,
                               input logic [31:0] d, input logic err, input bit track);
    bit          accepted;
    logic [3:0]  flags;
    logic        rden;
    logic [4:0]  expRd;
    logic [31:0] expData;
    logic        lok;
    logic        sok;
    i_req_valid   = 1'b1;
    i_req_load    = ld;
    i_req_info    = info;
    i_req_rd      = rd;
    i_req_offset  = off;
    i_req_misalgn = mis;
    accepted = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (o_req_ready) begin
        accepted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!accepted) begin
      failNow("issue_timeout");
      i_req_valid = 1'b0;
      return;
    end
    if (track) begin
      flags   = {ld & mis, ld & ~mis & err, ~ld & mis, ~ld & ~mis & err};
      rden    = ld & ~mis & ~err;
      expRd   = rden ? rd : 5'd0;
      expData = rden ? refLoad(info, off, d) : 32'h0;
      lok     = rden;
      sok     = ~ld & ~mis & ~err;
      sbQ.push_back({rden, expRd, expData, flags, lok, sok});
      if (!mis) rspQ.push_back('{port, d, err, lastMisHs});
      else      lastMisHs = issued + 1;
      issued++;
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 3000; c++) begin
      if (sbQ.size() == 0 && rspQ.size() == 0) break;
      @(posedge clk); #1;
    end
    if (sbQ.size() != 0 || rspQ.size() != 0) failNow("drain_timeout");
  endtask

  // Memory model: answers queued accesses in order, holding each while rsp_ready is low
  initial begin
    rsp_t e;
    bit   acc;
    i_rsp_valid = '0;
    i_rsp_data  = '0;
    i_rsp_err   = '0;
    @(posedge clk); #2;
    forever begin
      if (rspQ.size() > 0 && !rspHold && rst_n && hsCount >= rspQ[0].needHs) begin
        e = rspQ.pop_front();
        for (int p = 0; p < NSRC; p++) i_rsp_data[p*XLEN +: XLEN] = $urandom;
        i_rsp_data[e.port*XLEN +: XLEN] = e.data;
        i_rsp_err            = NSRC'($urandom);
        i_rsp_err[e.port]    = e.err;
        i_rsp_valid          = '0;
        i_rsp_valid[e.port]  = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          acc = o_rsp_ready;
          @(posedge clk); #2;
          if (acc) break;
        end
        if (!acc) failNow("rsp_accept");
        i_rsp_valid = '0;
        i_rsp_err   = NSRC'($urandom);
      end else begin
        @(posedge clk); #2;
      end
    end
  end

  // WB-side monitor: drives wb_ready and checks every presented record
  initial begin
    logic [42:0] cur;
    logic [42:0] holdSnap;
    logic [43:0] exp;
    bit          holdPending;
    holdPending = 1'b0;
    i_wb_ready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_wb_ready = (forceStall > 0) ? 1'b0 : ($urandom_range(99) < rdyPct);
      @(negedge clk);
      if (!rst_n) begin
        holdPending = 1'b0;
        continue;
      end
      cur = {o_wb_valid, o_wb_rden, o_wb_rd_index, o_wb_rd_data, o_load_misalgn_to_eiu,
             o_load_buserr_to_eiu, o_store_misalgn_to_eiu, o_store_buserr_to_eiu};
      if (holdPending) checkOutput("record_hold", 64'(cur), 64'(holdSnap));
      holdPending = 1'b0;
      if (o_wb_valid) begin
        checkOutput("rsp_ready_busy", 64'(o_rsp_ready), 64'(i_wb_ready));
        if (i_wb_ready) begin
          if (sbQ.size() == 0) begin
            failNow("unexpected_record");
          end else begin
            exp = sbQ.pop_front();
            checkOutput("record", 64'({cur[41:0], o_load_success, o_store_success}), 64'(exp));
          end
          hsCount++;
        end else begin
          holdPending = 1'b1;
          holdSnap    = cur;
          if (forceStall > 0) forceStall--;
        end
      end else begin
        checkOutput("idle_outputs", 64'({o_rsp_ready, o_load_success, o_store_success, cur[41:0]}),
                    64'({1'b1, 44'h0}));
      end
    end
  end

  initial begin
    i_req_valid   = 1'b0;
    i_req_load    = 1'b0;
    i_req_info    = '0;
    i_req_rd      = '0;
    i_req_offset  = '0;
    i_req_misalgn = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_wb_valid", 64'(o_wb_valid), 64'd0);
    checkOutput("reset_req_ready", 64'(o_req_ready), 64'd1);
    checkOutput("reset_rsp_ready", 64'(o_rsp_ready), 64'd1);
    checkOutput("reset_record", 64'({o_wb_rden, o_wb_rd_index, o_wb_rd_data, o_load_success,
                o_store_success, o_load_misalgn_to_eiu, o_load_buserr_to_eiu,
                o_store_misalgn_to_eiu, o_store_buserr_to_eiu}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] lbu offset 2 from DTCM");
    applyStimulus(1'b1, 5'b00010, 5'd5, 2'd2, 1'b0, 0, 32'h80FF7F01, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] back-to-back lh from ITCM then lb from DTCM");
    applyStimulus(1'b1, 5'b01000, 5'd7, 2'd2, 1'b0, 1, 32'h80011234, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'b10000, 5'd9, 2'd3, 1'b0, 0, 32'h7F000000, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] fill queue, then retire with a new issue");
    rspHold = 1'b1;
    applyStimulus(1'b1, 5'b00100, 5'd1, 2'd0, 1'b0, 0, 32'hDEADBEEF, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'b00001, 5'd2, 2'd2, 1'b0, 1, 32'hCAFE0123, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("full_req_ready", 64'(o_req_ready), 64'd0);
    @(posedge clk); #1;
    rspHold = 1'b0;
    applyStimulus(1'b1, 5'b00010, 5'd3, 2'd1, 1'b0, 0, 32'h0000A500, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] misaligned store behind a pending load");
    applyStimulus(1'b1, 5'b00100, 5'd4, 2'd0, 1'b0, 0, 32'h12345678, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'b00000, 5'd0, 2'd1, 1'b1, 0, 32'h0, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] bus error held under WB stall");
    forceStall = 3;
    applyStimulus(1'b1, 5'b00100, 5'd6, 2'd0, 1'b0, 1, 32'h55AA55AA, 1'b1, 1'b1);
    applyStimulus(1'b1, 5'b01000, 5'd8, 2'd0, 1'b0, 0, 32'h0000F00D, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] randomized traffic");
    rdyPct = 70;
    for (int n = 0; n < 300; n++) begin
      logic [4:0] info;
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end else begin
        info = ($urandom_range(9) == 0) ? 5'($urandom) : (5'b00001 << $urandom_range(4));
        applyStimulus(1'($urandom_range(1)), info, 5'($urandom), 2'($urandom),
                      ($urandom_range(7) == 0), $urandom_range(NSRC-1), $urandom,
                      ($urandom_range(9) == 0), 1'b1);
      end
    end
    waitDrain();

    $display("[TB] reset with two accesses pending");
    rdyPct = 100;
    rspHold = 1'b1;
    applyStimulus(1'b1, 5'b00100, 5'd10, 2'd0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'b00100, 5'd11, 2'd0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_req_ready", 64'(o_req_ready), 64'd1);
    checkOutput("midreset_outputs", 64'({o_wb_valid, o_wb_rden, o_wb_rd_index, o_wb_rd_data,
                o_load_misalgn_to_eiu, o_load_buserr_to_eiu, o_store_misalgn_to_eiu,
                o_store_buserr_to_eiu}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rspHold = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("post_reset_no_record", 64'(o_wb_valid), 64'd0);
    end
    @(posedge clk); #1;
    applyStimulus(1'b1, 5'b10000, 5'd12, 2'd1, 1'b0, 1, 32'h0000C300, 1'b0, 1'b1);
    waitDrain();
    @(negedge clk);
    checkOutput("final_req_ready", 64'(o_req_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
